// File: rtl/adder_result_accum_if.sv
// Bus between the adder pipeline, the frame accumulator and the result sink.
// The accumulator is the slave; the adder/issuer and the sink together act as the master.
interface adder_result_accum_if #(
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic [7:0]       sum;
    logic             cout;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             acc_ovf;
    logic             stall;
    logic             drop_err;

    modport master (
        output in_valid, sum, cout, acc_ready,
        input  acc_out, acc_valid, acc_ovf, stall, drop_err
    );

    modport slave (
        input  in_valid, sum, cout, acc_ready,
        output acc_out, acc_valid, acc_ovf, stall, drop_err
    );
endinterface

// File: rtl/adder_result_accum.sv
// Frame accumulator behind the pipelined 8-bit adder: aligns issue tags with the
// adder result, sums COUNT_N results per frame and offers each total on a valid/ready register.
module adder_result_accum #(
    parameter int PIPE_LAT = 2,
    parameter int ACC_W    = 16,
    parameter int COUNT_N  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_result_accum_if.slave  bus
);
    localparam int CNT_W = (COUNT_N > 1) ? $clog2(COUNT_N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_N - 1);

    typedef enum logic {ACC_IDLE = 1'b0, ACC_RUN  = 1'b1} acc_state_t;
    typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

    logic [PIPE_LAT-1:0] dv_q, dv_d;
    logic                dv_last;

    acc_state_t          acc_state_q, acc_state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_w_q, ovf_w_d;

    out_state_t          out_state_q, out_state_d;
    logic [ACC_W-1:0]    acc_out_q, acc_out_d;
    logic                acc_ovf_q, acc_ovf_d;
    logic                drop_err_q, drop_err_d;

    logic [ACC_W-1:0]    res;
    logic [ACC_W-1:0]    acc_base;
    logic [ACC_W-1:0]    sum_w;
    logic                sum_carry;
    logic                last_slot;
    logic                frame_done;
    logic                out_full;
    logic                load;
    logic                drop;

    // The tag travels PIPE_LAT stages so dv_last is high exactly while {cout,sum} is valid.
    assign dv_d[0] = bus.in_valid;
    genvar gi;
    generate
        for (gi = 1; gi < PIPE_LAT; gi++) begin : g_dv
            assign dv_d[gi] = dv_q[gi-1];
        end
    endgenerate
    assign dv_last = dv_q[PIPE_LAT-1];

    assign res        = ACC_W'({bus.cout, bus.sum});
    assign acc_base   = (acc_state_q == ACC_RUN) ? acc_q : '0;
    assign {sum_carry, sum_w} = {1'b0, acc_base} + {1'b0, res};
    assign last_slot  = (cnt_q == CNT_LAST);
    assign frame_done = dv_last & last_slot;

    assign out_full = (out_state_q == OUT_FULL);
    // A full register being drained on this edge can take the new total at the same time.
    assign load     = frame_done & (~out_full | bus.acc_ready);
    assign drop     = frame_done & out_full & ~bus.acc_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_q        <= '0;
            acc_state_q <= ACC_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_w_q     <= 1'b0;
            out_state_q <= OUT_EMPTY;
            acc_out_q   <= '0;
            acc_ovf_q   <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            dv_q        <= dv_d;
            acc_state_q <= acc_state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_w_q     <= ovf_w_d;
            out_state_q <= out_state_d;
            acc_out_q   <= acc_out_d;
            acc_ovf_q   <= acc_ovf_d;
            drop_err_q  <= drop_err_d;
        end
    end

    always_comb begin
        acc_state_d = acc_state_q;
        if (dv_last) begin
            acc_state_d = last_slot ? ACC_IDLE : ACC_RUN;
        end

        out_state_d = out_state_q;
        case (out_state_q)
            OUT_EMPTY: if (frame_done) out_state_d = OUT_FULL;
            OUT_FULL:  if (bus.acc_ready && !frame_done) out_state_d = OUT_EMPTY;
            default:   out_state_d = OUT_EMPTY;
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_w_d = ovf_w_q;
        if (dv_last) begin
            if (last_slot) begin
                acc_d   = '0;
                cnt_d   = '0;
                ovf_w_d = 1'b0;
            end else begin
                acc_d   = sum_w;
                cnt_d   = cnt_q + CNT_W'(1);
                ovf_w_d = ovf_w_q | sum_carry;
            end
        end

        acc_out_d  = acc_out_q;
        acc_ovf_d  = acc_ovf_q;
        drop_err_d = drop_err_q | drop;
        if (load) begin
            acc_out_d = sum_w;
            acc_ovf_d = ovf_w_q | sum_carry;
        end
    end

    assign bus.acc_out   = acc_out_q;
    assign bus.acc_valid = out_full;
    assign bus.acc_ovf   = acc_ovf_q;
    assign bus.drop_err  = drop_err_q;
    assign bus.stall     = out_full & ~bus.acc_ready & last_slot;
endmodule
